// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard character path.
package kbd_pkg;

   localparam int unsigned KBD_DATA_W              = 8;
   localparam logic [7:0]  KBD_ASCII_MIN           = 8'h41;
   localparam logic [7:0]  KBD_ASCII_MAX           = 8'h5A;
   localparam int unsigned KBD_FIFO_DEPTH_LOG2_DEF = 4;

   // Only upper-case letters are queued; everything else from the scan stage is ignored.
   function automatic logic kbd_is_queueable(input logic [KBD_DATA_W-1:0] c);
      return (c >= KBD_ASCII_MIN) && (c <= KBD_ASCII_MAX);
   endfunction

endpackage

// File: rtl/kbd_event_detect.sv
// Turns the level-type key outputs of the scan stage into one push pulse per new make event.
module kbd_event_detect
   import kbd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [KBD_DATA_W-1:0] key_ascii,
   input  logic                  key_state,
   output logic                  push_evt
);

   logic                  key_state_q, key_state_d;
   logic [KBD_DATA_W-1:0] key_ascii_q, key_ascii_d;

   always_comb begin
      key_state_d = key_state;
      key_ascii_d = key_ascii;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_state_q <= 1'b0;
         key_ascii_q <= '0;
      end else begin
         key_state_q <= key_state_d;
         key_ascii_q <= key_ascii_d;
      end
   end

   // A changed code while still held is a second key (rollover); an unchanged held code is
   // typematic repeat and must not re-fire.
   always_comb begin
      push_evt = key_state
               & (~key_state_q | (key_ascii != key_ascii_q))
               & kbd_is_queueable(key_ascii);
   end

endmodule

// File: rtl/ps2_key_fifo.sv
// Keystroke queue between the PS/2 decoder and the CPU keyboard registers.
// Optional interrupt output is enabled by defining PS2_KEY_FIFO_IRQ_EN.
module ps2_key_fifo
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = KBD_FIFO_DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [KBD_DATA_W-1:0] key_ascii,
   input  logic                  key_state,
   input  logic                  rd_en,
   output logic [KBD_DATA_W-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   input  logic                  ovf_clr,
`ifdef PS2_KEY_FIFO_IRQ_EN
   input  logic                  irq_ack,
   output logic                  irq,
`endif
   output logic                  overflow
);

   localparam int unsigned       DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

   logic                  push_evt;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  ovf_set;

   logic [KBD_DATA_W-1:0] mem_q [DEPTH];
   logic [KBD_DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [KBD_DATA_W-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;

   kbd_event_detect u_event_detect (
      .clk       (clk),
      .rst       (rst),
      .key_ascii (key_ascii),
      .key_state (key_state),
      .push_evt  (push_evt)
   );

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_CNT);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
   // There is no bypass: a pop on an empty FIFO is ignored even if a push arrives.
   assign pop_ok  = rd_en & ~empty;
   assign push_ok = push_evt & (~full | pop_ok);
   assign ovf_set = push_evt & full & ~pop_ok;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;

      if (push_ok) begin
         mem_d[wr_ptr_q] = key_ascii;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end

      // Reads come from mem_q, so a full-FIFO push into the same slot never corrupts the pop.
      if (pop_ok) begin
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
         rd_ptr_d   = rd_ptr_q + 1'b1;
      end

      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // Storage is not reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;

`ifdef PS2_KEY_FIFO_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = irq_q;
      if (push_ok) begin
         irq_d = 1'b1;
      end else if (irq_ack) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo (DEPTH_LOG2 = 4).
module tb_ps2_key_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_ascii;
   logic       key_state;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       ovf_clr;
   logic       overflow;
`ifdef PS2_KEY_FIFO_IRQ_EN
   logic       irq;
   logic       irq_ack;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ps2_key_fifo #(.DEPTH_LOG2(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_ascii (key_ascii),
      .key_state (key_state),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .ovf_clr   (ovf_clr),
`ifdef PS2_KEY_FIFO_IRQ_EN
      .irq_ack   (irq_ack),
      .irq       (irq),
`endif
      .overflow  (overflow)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      key_ascii = 8'h00;
      key_state = 1'b0;
      rd_en     = 1'b0;
      ovf_clr   = 1'b0;
`ifdef PS2_KEY_FIFO_IRQ_EN
      irq_ack   = 1'b0;
`endif
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_rd_valid", rd_valid, 0);
`ifdef PS2_KEY_FIFO_IRQ_EN
      chk("rst_irq", irq, 0);
`endif

      // Single key held 50 cycles: exactly one push.
      key_ascii = 8'h41;
      key_state = 1'b1;
      tick();
      chk("t1_count", count, 1);
      chk("t1_empty", empty, 0);
      repeat (50) tick();
      chk("t1_hold_count", count, 1);
      key_state = 1'b0;
      tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("t1_rd_valid", rd_valid, 1);
      chk("t1_rd_data", rd_data, 8'h41);
      chk("t1_count0", count, 0);
      tick();
      chk("t1_valid_1cyc", rd_valid, 0);

      // Rollover: code changes while key_state stays high.
      key_state = 1'b1;
      key_ascii = 8'h41;
      tick();
      key_ascii = 8'h42;
      tick();
      key_ascii = 8'h43;
      tick();
      chk("t2_count3", count, 3);
      key_state = 1'b0;
      tick();
      key_ascii = 8'h20;
      key_state = 1'b1;
      tick();
      chk("t2_space_nopush", count, 3);
      key_state = 1'b0;
      rd_en     = 1'b1;
      tick();
      chk("t2_pop0", rd_data, 8'h41);
      tick();
      chk("t2_pop1", rd_data, 8'h42);
      tick();
      chk("t2_pop2", rd_data, 8'h43);
      chk("t2_pop2_valid", rd_valid, 1);
      rd_en = 1'b0;
      chk("t2_count0", count, 0);

      // Fill with A..P, then Q overflows.
      key_state = 1'b1;
      for (int i = 0; i < 16; i++) begin
         key_ascii = 8'h41 + 8'(i);
         tick();
      end
      chk("t3_full", full, 1);
      chk("t3_count16", count, 16);
      chk("t3_ovf_before", overflow, 0);
      key_ascii = 8'h51;
      tick();
      chk("t3_ovf", overflow, 1);
      chk("t3_count_still16", count, 16);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", overflow, 0);

      // Full FIFO: push Z and pop together.
      key_ascii = 8'h5A;
      rd_en     = 1'b1;
      tick();
      key_state = 1'b0;
      chk("t4_full_pop_data", rd_data, 8'h41);
      chk("t4_full_pop_valid", rd_valid, 1);
      chk("t4_full_count", count, 16);
      chk("t4_full_ovf", overflow, 0);
      // Remaining order must be B..P then Z; Q was lost.
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("t4_drain", rd_data, 32'h41 + 32'(i));
      end
      tick();
      chk("t4_tail_z", rd_data, 8'h5A);
      rd_en = 1'b0;
      chk("t4_drained", count, 0);
      chk("t4_empty", empty, 1);

      // Empty FIFO: push and pop together, pop ignored.
      key_ascii = 8'h41;
      key_state = 1'b1;
      rd_en     = 1'b1;
      tick();
      key_state = 1'b0;
      rd_en     = 1'b0;
      chk("t4_empty_count", count, 1);
      chk("t4_empty_no_valid", rd_valid, 0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("t4_empty_pop_data", rd_data, 8'h41);

      // Pops on empty are ignored.
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_empty_valid", rd_valid, 0);
         chk("t5_empty_data", rd_data, 8'h41);
         chk("t5_empty_count", count, 0);
      end
      rd_en = 1'b0;

      // Push/pop pairs walk the pointers past the wrap point.
      key_state = 1'b1;
      for (int i = 0; i < 20; i++) begin
         key_ascii = 8'h41 + 8'(i);
         rd_en     = 1'b0;
         tick();
         rd_en = 1'b1;
         tick();
         chk("t5_wrap_data", rd_data, 32'h41 + 32'(i));
         chk("t5_wrap_valid", rd_valid, 1);
      end
      rd_en = 1'b0;
      chk("t5_wrap_count", count, 0);

      // Reset with 5 queued entries and a held key.
      for (int i = 0; i < 5; i++) begin
         key_ascii = 8'h41 + 8'(i);
         tick();
      end
      chk("t6_count5", count, 5);
`ifdef PS2_KEY_FIFO_IRQ_EN
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("t6_irq_acked", irq, 0);
`endif
      key_ascii = 8'h5A;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_count", count, 0);
      chk("t6_rst_rd_data", rd_data, 8'h00);
      chk("t6_rst_ovf", overflow, 0);
      chk("t6_rst_empty", empty, 1);
      tick();
      chk("t6_held_push", count, 1);
`ifdef PS2_KEY_FIFO_IRQ_EN
      chk("t6_irq_set", irq, 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("t6_irq_clr", irq, 0);
`endif
      repeat (5) tick();
      chk("t6_held_once", count, 1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("t6_pop_z", rd_data, 8'h5A);
      chk("t6_pop_valid", rd_valid, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Downstream of the PS/2 scan/decode stage. Consumes its level-type key outputs: an 8-bit ASCII code plus a "key held" state.
- Turns each new make event into one queued character.
- Buffers characters in a small synchronous FIFO so the CPU side can pop keystrokes at leisure without losing fast typing.
- Provides empty/full/count status and a sticky overflow flag to the keyboard I/O register logic.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries). Depth is always a power of two. Legal range 1..8.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_ascii  in  8  ASCII code from the scan stage. Holds its last value between keys.
- key_state  in  1  1 = key currently made, 0 = released
- rd_en  in  1  pop request, one cycle per character
- rd_data  out  8  popped character, registered
- rd_valid  out  1  one-cycle strobe marking rd_data valid
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- count  out  DEPTH_LOG2+1  current number of entries
- overflow  out  1  sticky: a character was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow

Behaviour:
- Event detect:
  - Registers key_state_d and key_ascii_d every cycle.
  - push_evt = key_state & (~key_state_d | (key_ascii != key_ascii_d)) & (key_ascii in 0x41..0x5A).
  - This fires once per new key, including a second key made while the first is still held.
  - A held key never re-fires, so typematic repeats are suppressed.
- Push timing: the write happens on the edge ending the push_evt cycle. empty/count/full reflect the new entry immediately after that edge.
- Pop timing:
  - rd_en with !empty: on the next edge, rd_data <= mem[rd_ptr], rd_valid <= 1, rd_ptr++ and count--.
  - Read latency is 1 cycle. rd_valid is high for exactly 1 cycle per accepted pop.
- rd_en while empty: ignored. rd_valid stays 0, rd_data holds its value, pointers and count are unchanged.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen and count is unchanged.
  - Empty FIFO: push accepted, pop ignored (no bypass).
  - Full FIFO: both happen; overflow is not set.
- Push while full without pop: the character is dropped, memory and pointers are unchanged, and overflow is set.
- Overflow clear: ovf_clr clears overflow. If a new overflow occurs in the same cycle, set wins.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth. count is a separate DEPTH_LOG2+1-bit counter. full = (count == depth), empty = (count == 0).
- Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_data=0x00, rd_valid=0, key_state_d=0, key_ascii_d=0x00. Memory contents are don't-care.
- Reset mid-operation: queued characters are discarded. A key held through reset is enqueued once on the first cycle after reset, because key_state_d resets to 0.

Optional Feature:
- Macro: PS2_KEY_FIFO_IRQ_EN.
- When defined:
  - Adds ports irq (out, 1) and irq_ack (in, 1).
  - irq is registered: set on any accepted push, cleared by irq_ack. Set wins on the same cycle.
  - Reset value of irq is 0.
- When undefined: neither port exists and there is no irq logic.

Decomposition:
- Package kbd_pkg holds:
  - KBD_DATA_W = 8
  - KBD_ASCII_MIN = 8'h41
  - KBD_ASCII_MAX = 8'h5A
  - KBD_FIFO_DEPTH_LOG2_DEF = 4
- Sub-module kbd_event_detect: input registers plus the push_evt equation, with one output pulse.
- FIFO storage, pointers and status stay in ps2_key_fifo.

Test Plan:
- Reset, then key_state 0->1 with key_ascii=0x41 held 50 cycles -> exactly one push; count=1, empty=0. rd_en pulse -> next cycle rd_valid=1, rd_data=0x41, count=0.
- key_state held 1 while key_ascii changes 0x41->0x42->0x43 -> 3 entries. Pops return 0x41, 0x42, 0x43 in order. key_ascii=0x20 with key_state rising -> no push.
- 17 distinct key events with DEPTH_LOG2=4 and no pops -> full=1 after the 16th, overflow=1 after the 17th. 16 pops return the first 16 characters; the 17th is lost. ovf_clr -> overflow=0.
- Full FIFO with push_evt and rd_en in the same cycle -> count stays 16, overflow stays 0, the oldest character is popped, and the new one appears at the tail. Empty FIFO with push_evt and rd_en together -> count=1, rd_valid=0.
- rd_en on empty for 3 cycles -> rd_valid never asserts, rd_data unchanged, count=0. Then 20 push/pop pairs -> pointers wrap past 15 with data order preserved.
- rst asserted with 5 entries queued and key_state=1, key_ascii=0x5A -> after release: count=0, rd_data=0x00, overflow=0. Next cycle one push of 0x5A. With PS2_KEY_FIFO_IRQ_EN: irq=1 after the push; irq_ack -> 0.
